mem_port_arbiter: RTL and testbench

- Shares one unified single-port memory between instruction fetch and data access, as needed by a multi-cycle or unified-memory build of the MIPS32 core.
- Arbitrates the two requesters and keeps one access outstanding at a time.
- Sequences the fixed-latency memory and returns each requester's read data or write acknowledge.
- Data has priority; a starvation guard guarantees fetch progress.

---
 rtl/mem_port_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter for a unified single-port memory.
// One access in flight; data wins unless fetch has starved.
module mem_port_arbiter #(
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [3:0] LAT4  = 4'(MEM_LAT);
  localparam logic [3:0] SMAX4 = 4'(STARVE_MAX);

  state_t     state, state_nx;
  logic [3:0] cnt;
  logic [3:0] scnt;
  logic       owner;
  logic       owner_we;
  logic       if_win;
  logic       d_win;

  always_comb begin
    if_win    = 1'b0;
    d_win     = 1'b0;
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    state_nx  = state;
    unique case (state)
      IDLE: begin
        if (!rst) begin
          if (if_req && (scnt == SMAX4 || !d_req))
            if_win = 1'b1;
          else if (d_req)
            d_win = 1'b1;
          if (if_win) begin
            if_gnt   = 1'b1;
            mem_req  = 1'b1;
            mem_addr = if_addr;
          end else if (d_win) begin
            d_gnt     = 1'b1;
            mem_req   = 1'b1;
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
          end
          if (if_win || d_win)
            state_nx = WAIT;
        end
      end
      WAIT: begin
        if (cnt == 4'd1)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      scnt      <= '0;
      owner     <= 1'b0;
      owner_we  <= 1'b0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      state     <= state_nx;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      if (state == IDLE) begin
        if (if_win) begin
          owner    <= 1'b0;
          owner_we <= 1'b0;
          cnt      <= LAT4;
          scnt     <= '0;
        end else if (d_win) begin
          owner    <= 1'b1;
          owner_we <= d_we;
          cnt      <= LAT4;
          // only data grants that make fetch wait count toward starvation
          if (if_req && scnt < SMAX4)
            scnt <= scnt + 4'd1;
        end
      end else begin
        cnt <= cnt - 4'd1;
        if (cnt == 4'd1) begin
          if (owner) begin
            d_rvalid <= 1'b1;
            d_rdata  <= owner_we ? 32'd0 : mem_rdata;
          end else begin
            if_rvalid <= 1'b1;
            if_rdata  <= mem_rdata;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter.
// Timestamp-based reference model predicts every output each cycle.
module tb_mem_port_arbiter;

  localparam int LAT = 3;
  localparam int SM  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;

  logic        s_rst = 1'b1;
  logic        s_if_req = 1'b0;
  logic [31:0] s_if_addr = '0;
  logic        s_if_gnt, s_if_rvalid;
  logic [31:0] s_if_rdata;
  logic        s_d_req = 1'b0;
  logic        s_d_we = 1'b0;
  logic [31:0] s_d_addr = '0;
  logic [31:0] s_d_wdata = '0;
  logic        s_d_gnt, s_d_rvalid;
  logic [31:0] s_d_rdata;
  logic        s_mem_req, s_mem_we;
  logic [31:0] s_mem_addr, s_mem_wdata;
  logic [31:0] s_mem_rdata = '0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MEM_LAT(LAT), .STARVE_MAX(SM)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(4)) u_dut1 (
    .clk(clk), .rst(s_rst),
    .if_req(s_if_req), .if_addr(s_if_addr), .if_gnt(s_if_gnt),
    .if_rvalid(s_if_rvalid), .if_rdata(s_if_rdata),
    .d_req(s_d_req), .d_we(s_d_we), .d_addr(s_d_addr),
    .d_wdata(s_d_wdata), .d_gnt(s_d_gnt), .d_rvalid(s_d_rvalid),
    .d_rdata(s_d_rdata), .mem_req(s_mem_req), .mem_we(s_mem_we),
    .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
    .mem_rdata(s_mem_rdata)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] hash(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hA5A50F0F;
  endfunction

  typedef struct {
    int          due;
    bit          port;
    logic [31:0] data;
  } resp_t;

  typedef struct {
    int          due;
    logic [31:0] addr;
  } rd_t;

  resp_t       pend[$];
  rd_t         mq[$];
  byte         order[$];
  int          cyc = 0;
  int          free_at = 0;
  int          streak = 0;
  int          mode = 0;
  bit          g_if = 0;
  bit          g_d = 0;
  logic        obs_if_gnt;
  logic [31:0] e_ird = '0;
  logic [31:0] e_drd = '0;

  task automatic step(input bit r);
    bit          e_irv, e_drv, fw, dw;
    logic [31:0] e_addr, e_wd;
    @(negedge clk);
    rst = r;
    if (!(if_req && !g_if)) begin
      if_req  = (mode == 1 || mode == 4) ? 1'b1 :
                (mode == 0) ? ($urandom % 3 != 0) : 1'b0;
      if_addr = {20'd0, 10'($urandom), 2'b00};
    end
    if (!(d_req && !g_d)) begin
      d_req   = (mode == 1 || mode == 5) ? 1'b1 :
                (mode == 0) ? ($urandom % 2 == 0) : 1'b0;
      d_we    = (mode == 5) ? 1'b0 : 1'($urandom);
      d_addr  = {20'd1, 10'($urandom), 2'b00};
      d_wdata = $urandom;
    end
    mem_rdata = $urandom;
    while (mq.size() > 0 && mq[0].due < cyc) void'(mq.pop_front());
    if (mq.size() > 0 && mq[0].due == cyc) mem_rdata = hash(mq[0].addr);
    #1;
    e_irv = 0;
    e_drv = 0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      if (pend[0].port) begin
        e_drv = 1;
        e_drd = pend[0].data;
      end else begin
        e_irv = 1;
        e_ird = pend[0].data;
      end
      void'(pend.pop_front());
    end
    check("if_rvalid", if_rvalid, e_irv);
    check("d_rvalid", d_rvalid, e_drv);
    check("if_rdata", if_rdata, e_ird);
    check("d_rdata", d_rdata, e_drd);
    fw = 0;
    dw = 0;
    if (!rst && cyc >= free_at) begin
      fw = if_req && (streak == SM || !d_req);
      dw = d_req && !fw;
    end
    e_addr = fw ? if_addr : dw ? d_addr : 32'd0;
    e_wd   = dw ? d_wdata : 32'd0;
    check("if_gnt", if_gnt, fw);
    check("d_gnt", d_gnt, dw);
    check("mem_req", mem_req, fw | dw);
    check("mem_we", mem_we, dw & d_we);
    check("mem_addr", mem_addr, e_addr);
    check("mem_wdata", mem_wdata, e_wd);
    obs_if_gnt = if_gnt;
    if (mem_req && !mem_we) mq.push_back('{cyc + LAT, mem_addr});
    if (fw || dw) begin
      free_at = cyc + LAT + 1;
      pend.push_back('{cyc + LAT + 1, dw,
                       fw ? hash(if_addr) : (d_we ? 32'd0 : hash(d_addr))});
      if (fw) streak = 0;
      else if (if_req && streak < SM) streak++;
      if (mode == 1) order.push_back(fw ? "F" : "D");
    end
    if (rst) begin
      pend.delete();
      e_ird = '0;
      e_drd = '0;
      free_at = cyc + 1;
      streak = 0;
    end
    g_if = fw;
    g_d  = dw;
    cyc++;
  endtask

  initial begin
    string exp_s;
    int    k;
    int    last;
    // MEM_LAT=1 instance: directed fetch, store and idle
    repeat (2) @(negedge clk);
    s_rst = 0;
    s_if_req = 1;
    s_if_addr = 32'h40;
    #1;
    check("l1_if_gnt", s_if_gnt, 1);
    check("l1_mem_req", s_mem_req, 1);
    check("l1_mem_addr", s_mem_addr, 32'h40);
    check("l1_mem_we", s_mem_we, 0);
    @(negedge clk);
    s_if_req = 0;
    s_mem_rdata = 32'h8C010004;
    #1;
    check("l1_wait_req", {s_if_gnt, s_mem_req}, 0);
    @(negedge clk);
    s_mem_rdata = 32'h0;
    s_d_req = 1;
    s_d_we = 1;
    s_d_addr = 32'h100;
    s_d_wdata = 32'hDEADBEEF;
    #1;
    check("l1_if_rvalid", s_if_rvalid, 1);
    check("l1_if_rdata", s_if_rdata, 32'h8C010004);
    check("l1_d_gnt", s_d_gnt, 1);
    check("l1_st_we", s_mem_we, 1);
    check("l1_st_wdata", s_mem_wdata, 32'hDEADBEEF);
    check("l1_st_addr", s_mem_addr, 32'h100);
    @(negedge clk);
    s_d_req = 0;
    s_mem_rdata = 32'h12345678;
    #1;
    check("l1_if_pulse", s_if_rvalid, 0);
    @(negedge clk);
    #1;
    check("l1_d_rvalid", s_d_rvalid, 1);
    check("l1_st_rdata", s_d_rdata, 0);
    check("l1_st_if_rv", s_if_rvalid, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      check("l1_idle_act", {s_if_gnt, s_d_gnt, s_mem_req,
                            s_if_rvalid, s_d_rvalid}, 0);
      check("l1_idle_ird", s_if_rdata, 32'h8C010004);
      check("l1_idle_drd", s_d_rdata, 0);
    end

    // MEM_LAT=3 instance: random traffic with occasional resets
    step(1);
    step(1);
    mode = 0;
    for (int i = 0; i < 1500; i++) step($urandom_range(0, 299) == 0);

    // starvation guard order with both requesters held
    mode = 2;
    repeat (6) step(0);
    step(1);
    order.delete();
    mode = 1;
    k = 0;
    while (order.size() < 10 && k < 200) begin
      step(0);
      k++;
    end
    check("order_len", order.size(), 10);
    exp_s = "DDDDFDDDDF";
    for (int i = 0; i < 10 && i < order.size(); i++)
      check("order", order[i], exp_s[i]);

    // back-to-back loads: regrant lands in the rvalid cycle
    mode = 2;
    repeat (6) step(0);
    mode = 5;
    last = -1;
    for (int i = 0; i < 20; i++) begin
      step(0);
      if (g_d) begin
        if (last >= 0) check("b2b_gap", cyc - last, LAT + 1);
        last = cyc;
      end
    end

    // reset one cycle after a grant abandons the access
    mode = 2;
    repeat (6) step(0);
    mode = 4;
    k = 0;
    g_if = 0;
    while (!g_if && k < 20) begin
      step(0);
      k++;
    end
    check("rst_grant_seen", g_if, 1);
    step(0);
    step(1);
    step(0);
    check("rst_regrant", obs_if_gnt, 1);
    mode = 2;
    repeat (12) step(0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
